// File: rtl/div_ratio_monitor_if.sv
// Divider taps and status bundle between the clock divider and its monitor.
// The master side drives taps, enable and clear; the slave side reports status.
interface div_ratio_monitor_if;
  logic       en;
  logic       clk_2;
  logic       clk_4;
  logic       clk_8;
  logic       clk_16;
  logic       err_clr;
  logic [3:0] locked;
  logic [3:0] err;
  logic       all_locked;

  modport master (
    output en,
    output clk_2,
    output clk_4,
    output clk_8,
    output clk_16,
    output err_clr,
    input  locked,
    input  err,
    input  all_locked
  );

  modport slave (
    input  en,
    input  clk_2,
    input  clk_4,
    input  clk_8,
    input  clk_16,
    input  err_clr,
    output locked,
    output err,
    output all_locked
  );
endinterface

// File: rtl/div_ratio_monitor.sv
// Checks that the ripple divider taps run at exactly 1/2, 1/4, 1/8, 1/16 of clk.
// Per channel: synchronizer, rise detect, period counter, lock FSM, sticky error.
module div_ratio_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 6
) (
  input logic               clk,
  input logic               rst,
  div_ratio_monitor_if.slave mon
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    LOCKED
  } state_t;

  function automatic logic [CNT_W-1:0] exp_of(input int ch);
    return CNT_W'(2) << ch;
  endfunction

  logic [3:0]             raw;
  logic [3:0]             synced;
  logic [3:0]             hist_q;
  logic [3:0]             rise;
  logic [3:0]             new_err;
  logic [3:0]             err_q;
  logic [3:0]             err_d;
  logic [3:0]             locked_q;
  logic                   all_q;
  logic [SYNC_STAGES-1:0] sync_q  [4];
  state_t                 state_q [4];
  state_t                 state_d [4];
  logic [CNT_W-1:0]       cnt_q   [4];
  logic [CNT_W-1:0]       cnt_d   [4];
  logic [GW-1:0]          good_q  [4];
  logic [GW-1:0]          good_d  [4];

  assign raw = {mon.clk_16, mon.clk_8, mon.clk_4, mon.clk_2};

  always_comb begin
    synced = '0;
    for (int i = 0; i < 4; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign rise = synced & ~hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= '0;
      end
      hist_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      end
      hist_q <= synced;
    end
  end

  always_comb begin
    new_err = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      good_d[i]  = good_q[i];
      if (!mon.en) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        good_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            state_d[i] = ARMED;
            cnt_d[i]   = '0;
          end
          ARMED: begin
            good_d[i] = '0;
            if (rise[i]) begin
              state_d[i] = MEASURE;
              cnt_d[i]   = CNT_W'(1);
            end else begin
              cnt_d[i] = '0;
            end
          end
          MEASURE, LOCKED: begin
            if (rise[i]) begin
              cnt_d[i] = CNT_W'(1);
              if (cnt_q[i] == exp_of(i)) begin
                if (state_q[i] == MEASURE) begin
                  good_d[i] = good_q[i] + GW'(1);
                  if (good_q[i] + GW'(1) == GW'(LOCK_COUNT))
                    state_d[i] = LOCKED;
                end
              end else begin
                new_err[i] = 1'b1;
                good_d[i]  = '0;
                state_d[i] = MEASURE;
              end
            end else if (cnt_q[i] == (exp_of(i) << 1)) begin
              // Two full periods without an edge: treat the tap as stuck.
              new_err[i] = 1'b1;
              good_d[i]  = '0;
              cnt_d[i]   = '0;
              state_d[i] = ARMED;
            end else if (!(&cnt_q[i])) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // A fresh error outranks a simultaneous clear.
  assign err_d = (err_q & ~{4{mon.err_clr}}) | new_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        good_q[i]  <= '0;
      end
      err_q    <= '0;
      locked_q <= '0;
      all_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        good_q[i]   <= good_d[i];
        locked_q[i] <= (state_d[i] == LOCKED);
      end
      err_q <= err_d;
      all_q <= &locked_q;
    end
  end

  assign mon.locked     = locked_q;
  assign mon.err        = err_q;
  assign mon.all_locked = all_q;

endmodule
